// File: rtl/muldiv_ctrl_pkg.sv
// Shared pipeline definitions for the HI/LO multiply/divide unit: op codes,
// controller states and the divider iteration count.
package muldiv_ctrl_pkg;

  localparam int DIV_ITER = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } muldiv_state_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_udiv_iter.sv
// Unsigned restoring divider: loads on start, runs DIV_ITER shift/subtract
// steps, then holds done with {rem, quot} until cleared or restarted.
module udiv_iter
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        clear,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [63:0] result
);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quot_q, quot_d;
  logic [31:0]      dsor_q, dsor_d;
  logic [32:0]      shifted;
  logic [32:0]      diff;

  assign done   = active_q & (cnt_q == CNT_W'(DIV_ITER));
  assign result = {rem_q, quot_q};

  always_comb begin
    shifted  = {rem_q, quot_q[31]};
    diff     = shifted - {1'b0, dsor_q};
    active_d = active_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dsor_d   = dsor_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      rem_d    = '0;
      quot_d   = dividend;
      dsor_d   = divisor;
    end else if (clear) begin
      active_d = 1'b0;
    end else if (active_q && !done) begin
      cnt_d = cnt_q + CNT_W'(1);
      // A zero divisor never borrows, giving all-ones quotient and rem = dividend.
      if (!diff[32]) begin
        rem_d  = diff[31:0];
        quot_d = {quot_q[30:0], 1'b1};
      end else begin
        rem_d  = shifted[31:0];
        quot_d = {quot_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dsor_q   <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dsor_q   <= dsor_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller with an iterative unsigned divider core.
// Optional MULDIV_DIV0_FAST_EN: divide-by-zero completes after one busy cycle.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken on a rising edge where req_valid & req_ready;
  // req_ready is high only in IDLE without flush, and never depends on req_valid.

  muldiv_op_t    op_e, op_q, op_d;
  muldiv_state_t state_q, state_d;
  logic [31:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic          neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d;
  logic          accept, is_mul_op, is_div_op, div0_fast;
  logic          core_start, core_clear, core_done;
  logic [63:0]   core_result;
  logic [31:0]   core_dividend, core_divisor, quot_u, rem_u;
  logic          sign_a, sign_b;
  logic [63:0]   product;

  assign op_e      = muldiv_op_t'(op);
  assign accept    = req_valid & req_ready;
  assign is_mul_op = (op_e == OP_MULT) | (op_e == OP_MULTU);
  assign is_div_op = (op_e == OP_DIV) | (op_e == OP_DIVU);

`ifdef MULDIV_DIV0_FAST_EN
  assign div0_fast = is_div_op & (b == 32'd0);
`else
  assign div0_fast = 1'b0;
`endif

  assign core_dividend = (op_e == OP_DIV) ? abs32(a) : a;
  assign core_divisor  = (op_e == OP_DIV) ? abs32(b) : b;
  assign quot_u        = core_result[31:0];
  assign rem_u         = core_result[63:32];

  // Sign-extending both operands makes one 64-bit multiply serve MULT and MULTU.
  assign sign_a  = (op_q == OP_MULT) & a_q[31];
  assign sign_b  = (op_q == OP_MULT) & b_q[31];
  assign product = {{32{sign_a}}, a_q} * {{32{sign_b}}, b_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul_op || div0_fast) state_d = S_MUL;
          else if (is_div_op)         state_d = S_DIV;
        end
      end
      S_MUL:   state_d = S_IDLE;
      S_DIV:   if (flush || core_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE) & ~flush;
    busy       = (state_q != S_IDLE);
    core_start = (state_q == S_IDLE) & req_valid & ~flush & is_div_op & ~div0_fast;
    core_clear = (state_q == S_DIV) & (flush | core_done);
    dbg_state  = state_q;
  end

  always_comb begin
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    if (accept) begin
      op_d       = op_e;
      a_d        = a;
      b_d        = b;
      neg_quot_d = (op_e == OP_DIV) & (a[31] ^ b[31]);
      neg_rem_d  = (op_e == OP_DIV) & a[31];
      if (op_e == OP_MTHI) hi_d = a;
      if (op_e == OP_MTLO) lo_d = a;
    end
    if (state_q == S_MUL && !flush) begin
      if (op_q == OP_MULT || op_q == OP_MULTU) begin
        hi_d = product[63:32];
        lo_d = product[31:0];
      end else begin
        hi_d = a_q;
        lo_d = (op_q == OP_DIV && a_q[31]) ? 32'd1 : 32'hFFFF_FFFF;
      end
    end
    if (state_q == S_DIV && !flush && core_done) begin
      hi_d = neg_rem_q  ? (32'd0 - rem_u)  : rem_u;
      lo_d = neg_quot_q ? (32'd0 - quot_u) : quot_u;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q       <= OP_NOP;
      a_q        <= '0;
      b_q        <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

  udiv_iter u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (core_start),
    .clear    (core_clear),
    .dividend (core_dividend),
    .divisor  (core_divisor),
    .done     (core_done),
    .result   (core_result)
  );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected {hi,lo} pushed at issue, popped
// when busy drops; also checks busy latency, flush and reset behaviour.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        req_ready, busy;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    int     ix, iy;
    logic [31:0] q, r;
    case (o)
      OP_MULT: begin
        sx = $signed(x);
        sy = $signed(y);
        return 64'(sx * sy);
      end
      OP_MULTU: return {32'd0, x} * {32'd0, y};
      OP_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      OP_DIV: begin
        if (y == 32'd0) return {x, (x[31] ? 32'd1 : 32'hFFFF_FFFF)};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        ix = $signed(x);
        iy = $signed(y);
        q = ix / iy;
        r = ix % iy;
        return {r, q};
      end
      OP_MTHI: return {x, cur_lo};
      OP_MTLO: return {cur_hi, x};
      default: return {cur_hi, cur_lo};
    endcase
  endfunction

  function automatic int latency(input logic [2:0] o, input logic [31:0] y);
    if (o == OP_MULT || o == OP_MULTU) return 1;
    if (o == OP_DIV || o == OP_DIVU) begin
`ifdef MULDIV_DIV0_FAST_EN
      if (y == 32'd0) return 1;
`endif
      return 33;
    end
    return 0;
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [63:0] exp_v;
    int cycles;
    int exp_lat;
    exp_q.push_back(model(o, x, y));
    exp_lat = latency(o, y);
    @(negedge clk);
    check_eq({tag, "_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    req_valid = 1'b0; op = OP_NOP; a = '0; b = '0;
    cycles = 0;
    @(negedge clk);
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    check_eq({tag, "_busy_cycles"}, 64'(cycles), 64'(exp_lat));
    exp_v = exp_q.pop_front();
    check_eq({tag, "_hilo"}, {hi, lo}, exp_v);
    cur_hi = exp_v[63:32];
    cur_lo = exp_v[31:0];
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_hilo", {hi, lo}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", 64'(req_ready), 64'd1);
    check_eq("idle_state", 64'(dbg_state), 64'(S_IDLE));

    // Directed
    do_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, "mult");
    do_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, "multu");
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(OP_DIVU,  32'd100, 32'd0, "divu_by0");
    do_op(OP_DIV,   32'hFFFF_FFFB, 32'd0, "div_neg_by0");
    do_op(OP_DIV,   32'd5, 32'd0, "div_pos_by0");
    do_op(OP_DIV,   32'd7, 32'hFFFF_FFFE, "div_7_m2");

    // MTHI then MTLO back-to-back
    @(negedge clk);
    req_valid = 1'b1; op = OP_MTHI; a = 32'h1234;
    exp_q.push_back({32'h1234, cur_lo});
    @(negedge clk);
    check_eq("mthi_busy", 64'(busy), 64'd0);
    check_eq("mthi_hilo", {hi, lo}, exp_q.pop_front());
    op = OP_MTLO; a = 32'h5678;
    exp_q.push_back({32'h1234, 32'h5678});
    @(negedge clk);
    req_valid = 1'b0; op = OP_NOP; a = '0;
    check_eq("mtlo_busy", 64'(busy), 64'd0);
    check_eq("mtlo_hilo", {hi, lo}, exp_q.pop_front());
    cur_hi = 32'h1234; cur_lo = 32'h5678;

    // Random mix
    for (int i = 0; i < 10; i++) begin
      logic [2:0]  ro;
      logic [31:0] rb;
      ro = 3'($urandom_range(1, 4));
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      do_op(ro, $urandom, rb, $sformatf("rand%0d", i));
    end

    // Flush DIVU at busy cycle 20, then rerun
    @(negedge clk);
    req_valid = 1'b1; op = OP_DIVU; a = 32'd10; b = 32'd3;
    @(negedge clk);
    req_valid = 1'b0; op = OP_NOP;
    repeat (19) @(negedge clk);
    check_eq("flush20_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush20_busy", 64'(busy), 64'd0);
    check_eq("flush20_state", 64'(dbg_state), 64'(S_IDLE));
    check_eq("flush20_hilo", {hi, lo}, {cur_hi, cur_lo});
    repeat (40) @(negedge clk);
    check_eq("flush20_hilo_late", {hi, lo}, {cur_hi, cur_lo});
    do_op(OP_DIVU, 32'd10, 32'd3, "divu_after_flush");

    // Flush coinciding with divide completion
    @(negedge clk);
    req_valid = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    req_valid = 1'b0; op = OP_NOP;
    repeat (32) @(negedge clk);
    check_eq("flush33_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush33_busy", 64'(busy), 64'd0);
    check_eq("flush33_hilo", {hi, lo}, {cur_hi, cur_lo});

    // Flush in MUL
    @(negedge clk);
    req_valid = 1'b1; op = OP_MULT; a = 32'd7; b = 32'd9;
    @(negedge clk);
    req_valid = 1'b0; op = OP_NOP;
    check_eq("flushmul_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flushmul_busy", 64'(busy), 64'd0);
    check_eq("flushmul_hilo", {hi, lo}, {cur_hi, cur_lo});

    // Request together with flush in IDLE is refused
    @(negedge clk);
    req_valid = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF; flush = 1'b1;
    #1;
    check_eq("flushidle_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    req_valid = 1'b0; op = OP_NOP; a = '0; flush = 1'b0;
    check_eq("flushidle_busy", 64'(busy), 64'd0);
    check_eq("flushidle_hilo", {hi, lo}, {cur_hi, cur_lo});

    // Reset mid-divide
    @(negedge clk);
    req_valid = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    req_valid = 1'b0; op = OP_NOP;
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_eq("midrst_hilo", {hi, lo}, 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("postrst_hilo", {hi, lo}, 64'd0);
    check_eq("postrst_busy", 64'(busy), 64'd0);
    cur_hi = '0; cur_lo = '0;
    do_op(OP_MULTU, 32'd6, 32'd7, "mul_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-002 SHALL have port resetn, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port req_valid, input, 1, operation request from execute stage.
REQ-004 SHALL have port req_ready, output, 1, request accepted when req_valid & req_ready at a rising edge.
REQ-005 SHALL have port op, input, 3, muldiv_op_t: NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 SHALL have ports a and b, input, 32 each, operands (rs, rt); MTHI/MTLO use a only.
REQ-007 SHALL have port flush, input, 1, pipeline flush; aborts the in-flight operation.
REQ-008 SHALL have port busy, output, 1, high while an operation is in flight; the stage reading HI/LO stalls on it.
REQ-009 SHALL have ports hi and lo, output, 32 each, architectural HI/LO registers.

Function
REQ-010 SHALL implement states IDLE, MUL, DIV; req_ready = (state == IDLE) & ~flush; busy = (state != IDLE).
REQ-011 SHALL, in IDLE on accept: MULT/MULTU -> MUL; DIV/DIVU -> DIV, latching operand signs and starting the divider core; MTHI/MTLO write a to HI/LO at the accepting edge and stay IDLE; NOP is ignored.
REQ-012 SHALL, in MUL, write the 64-bit product {HI,LO} at the next edge (signed for MULT, unsigned for MULTU) and return to IDLE: 1 busy cycle.
REQ-013 SHALL, for DIV/DIVU, feed the unsigned core with operand magnitudes (DIV) or raw operands (DIVU); the core takes 32 iteration cycles.
REQ-014 SHALL write HI = remainder and LO = quotient at the 33rd rising edge after the accepting edge, then return to IDLE; busy is low in the first cycle the new values are visible.
REQ-015 SHALL apply the DIV sign rule: quotient negated iff sign(a) xor sign(b); remainder negated iff sign(a).
REQ-016 SHALL make DIV 0x80000000 / 0xFFFFFFFF give LO = 0x80000000 and HI = 0x00000000.
REQ-017 SHALL make divide-by-zero deterministic: DIVU gives LO = 0xFFFFFFFF and HI = a; DIV gives HI = a and LO = 0x00000001 if a < 0, else 0xFFFFFFFF.
REQ-018 SHALL, on flush in MUL or DIV, return to IDLE at the next edge, leave HI/LO unchanged, and discard the core result.
REQ-019 SHALL give flush priority over completion in the same cycle: HI/LO are not written.
REQ-020 SHALL not accept a request that arrives together with flush in IDLE; HI/LO are unchanged.
REQ-021 SHALL restart the core at most once per accepted DIV; core done is ignored outside DIV.

Reset
REQ-022 SHALL, on resetn low and asynchronously, set state to IDLE and hi, lo to 0, and clear the core; busy = 0 and req_ready = 1 while in reset-released IDLE.
REQ-023 SHALL, on reset mid-operation, drop the operation with no HI/LO write after release.

Configuration
REQ-024 SHALL support macro MULDIV_DIV0_FAST_EN: when defined, a DIV/DIVU with b == 0 skips the core, writes the REQ-017 values at the first edge after acceptance, and is busy for 1 cycle.
REQ-025 SHALL, with MULDIV_DIV0_FAST_EN undefined, have divide-by-zero take the full REQ-014 latency with identical results.

Structure
REQ-026 SHALL place muldiv_op_t, the state enum and the constant DIV_ITER = 32 in the shared pipeline package.
REQ-027 SHALL instantiate one sub-module, udiv_iter: an unsigned 32-cycle restoring divider with start/done, clk and resetn, and a {rem, quot} output; sign handling stays in muldiv_ctrl.

Verification
REQ-028 SHALL cover: MULT a=0xFFFFFFFE, b=3 -> after 1 busy cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-029 SHALL cover: DIV a=-7 (0xFFFFFFF9), b=2 -> at edge 33 after accept LO=0xFFFFFFFD, HI=0xFFFFFFFF; busy high for exactly 33 cycles.
REQ-030 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 100/0 -> LO=0xFFFFFFFF, HI=100, latency checked with and without MULDIV_DIV0_FAST_EN.
REQ-031 SHALL cover: MTHI 0x1234 then MTLO 0x5678 back-to-back -> hi=0x1234, lo=0x5678, busy never asserted.
REQ-032 SHALL cover: DIVU 10/3 with flush at cycle 20 -> IDLE next cycle, HI/LO keep prior values; a new DIVU 10/3 then gives LO=3, HI=1.
REQ-033 SHALL cover: resetn asserted mid-DIV -> hi=lo=0 immediately and busy=0; no write after release.
